keypad_matrix_scanner: RTL and testbench

Scans a ROW_NUM x COL_NUM push-button matrix by driving one column low at a time and sampling the row lines, so the alarm clock can read its time-set keypad. It is the input-side counterpart of the seven-segment refresh logic: it time-multiplexes reads instead of writes. It synchronizes the rows, rejects ghosting, and debounces across whole scans. Each debounced key press is presented as one code on a valid/ready handshake to the time-setting controller.

---
 rtl/keypad_matrix_scanner_pkg.sv | 23 ++
 rtl/keypad_matrix_scanner_if.sv | 35 +++
 rtl/keypad_matrix_scanner_row_synchronizer.sv | 29 ++
 rtl/keypad_matrix_scanner.sv | 155 +++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_matrix_scanner_pkg.sv
// keypad_matrix_scanner_pkg
// Shared types and helpers for the keypad matrix scanner.
//   scan_state_t : scan FSM encoding (SCAN, EVAL)
//   code_width() : width of a key code for a given number of keys
//   key_none()   : NONE sentinel for the CODE_W+1 bit internal key state.
//                  The sentinel is the only value with the top bit set, so it
//                  can never collide with a real key code.
package keypad_matrix_scanner_pkg;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_EVAL = 1'b1
  } scan_state_t;

  function automatic int code_width(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

  function automatic logic [31:0] key_none(input int code_w);
    return 32'd1 << code_w;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if
// Key-event channel from the scanner to the time-setting controller.
//   o_Key_Code  : key code = row*COL_NUM + col
//   o_Key_Valid : code holds an unconsumed press event
//   i_Key_Ready : consumer accepts the event
//   o_Key_Held  : debounced state is a key
//   o_Overrun   : one-cycle pulse when an event was dropped
//   dbg_state   : scan FSM state, for observation only
// Handshake: an event transfers on every rising clock edge where o_Key_Valid
// and i_Key_Ready are both high. While o_Key_Valid is high and no transfer has
// happened, o_Key_Code does not change. o_Key_Valid does not depend on
// i_Key_Ready.
interface keypad_matrix_scanner_if #(
  parameter int CODE_W = 4
);
  import keypad_matrix_scanner_pkg::*;

  logic [CODE_W-1:0] o_Key_Code;
  logic              o_Key_Valid;
  logic              i_Key_Ready;
  logic              o_Key_Held;
  logic              o_Overrun;
  scan_state_t       dbg_state;

  modport master (
    output o_Key_Code, o_Key_Valid, o_Key_Held, o_Overrun, dbg_state,
    input  i_Key_Ready
  );

  modport slave (
    input  o_Key_Code, o_Key_Valid, o_Key_Held, o_Overrun, dbg_state,
    output i_Key_Ready
  );

endinterface

// File: rtl/keypad_matrix_scanner_row_synchronizer.sv
// keypad_matrix_scanner_row_synchronizer
// Two-flop synchronizer for a bus of independent asynchronous button lines.
// Resets to all ones, which is the idle level of pulled-up active-low inputs.
//   clk : clock
//   rst : synchronous active-high reset
//   d   : asynchronous inputs
//   q   : synchronized outputs
module keypad_matrix_scanner_row_synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a ROW_NUM x COL_NUM key matrix one column at a time, rejects ghosting
// (two or more keys down in a scan reads as no key), debounces across whole
// scans and presents each new debounced press as one event on a valid/ready
// channel backed by a one-entry holding register.
//   i_Clk   : clock
//   i_Reset : synchronous active-high reset
//   i_Rows  : asynchronous active-low row lines
//   o_Cols  : active-low column drive, exactly one bit low
//   key     : event channel (code, valid, ready, held, overrun, FSM state)
module keypad_matrix_scanner
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int ROW_NUM        = 4,
  parameter int COL_NUM        = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [ROW_NUM-1:0]     i_Rows,
  output logic [COL_NUM-1:0]     o_Cols,
  keypad_matrix_scanner_if.master key
);

  localparam int CODE_W = code_width(ROW_NUM * COL_NUM);
  localparam int KEY_W  = CODE_W + 1;
  localparam int COL_W  = $clog2(COL_NUM);
  localparam int SET_W  = $clog2(SETTLE_CYCLES);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [KEY_W-1:0] KEY_NONE = KEY_W'(key_none(CODE_W));
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_NUM - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  logic [ROW_NUM-1:0]              rows_s;
  scan_state_t                     state;
  logic [COL_W-1:0]                col;
  logic [SET_W-1:0]                settle;
  logic [ROW_NUM-1:0][COL_NUM-1:0] image;
  logic [KEY_W-1:0]                prev_cand;
  logic [CNT_W-1:0]                stable_cnt;
  logic [KEY_W-1:0]                accepted;
  logic [CODE_W-1:0]               code_q;
  logic                            valid_q;
  logic                            overrun_q;

  logic [KEY_W-1:0]                cand;
  logic                            seen;
  logic                            multi;
  logic [CNT_W-1:0]                next_cnt;
  logic                            accept_now;
  logic                            press_evt;

  keypad_matrix_scanner_row_synchronizer #(
    .WIDTH (ROW_NUM)
  ) u_row_sync (
    .clk (i_Clk),
    .rst (i_Reset),
    .d   (i_Rows),
    .q   (rows_s)
  );

  assign o_Cols = ~(COL_NUM'(1) << col);

  // Candidate for the completed scan: the single low bit's code, else NONE.
  always_comb begin
    cand  = KEY_NONE;
    seen  = 1'b0;
    multi = 1'b0;
    for (int r = 0; r < ROW_NUM; r++) begin
      for (int k = 0; k < COL_NUM; k++) begin
        if (!image[r][k]) begin
          if (seen) multi = 1'b1;
          seen = 1'b1;
          cand = KEY_W'(r * COL_NUM + k);
        end
      end
    end
    if (multi) cand = KEY_NONE;
  end

  always_comb begin
    if (cand == prev_cand) begin
      next_cnt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_W'(1);
    end else begin
      next_cnt = CNT_W'(1);
    end
    accept_now = (state == ST_EVAL) && (next_cnt == CNT_MAX) && (cand != accepted);
    // Entering a key state (from NONE or another key) is a press; entering
    // NONE is a release and produces no event.
    press_evt  = accept_now && (cand != KEY_NONE);
  end

  // Scan counters, FSM, debouncer and output register. EVAL runs alongside
  // the first settle cycle of the next scan, so scanning never pauses.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= ST_SCAN;
      col        <= '0;
      settle     <= '0;
      image      <= '0;
      prev_cand  <= KEY_NONE;
      stable_cnt <= '0;
      accepted   <= KEY_NONE;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;

      if (settle == SET_LAST) begin
        settle <= '0;
        for (int r = 0; r < ROW_NUM; r++) begin
          image[r][col] <= rows_s[r];
        end
        col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
      end else begin
        settle <= settle + SET_W'(1);
      end

      case (state)
        ST_SCAN: begin
          if ((settle == SET_LAST) && (col == COL_LAST)) state <= ST_EVAL;
        end
        ST_EVAL: begin
          state      <= ST_SCAN;
          prev_cand  <= cand;
          stable_cnt <= next_cnt;
          if (accept_now) accepted <= cand;
        end
        default: state <= ST_SCAN;
      endcase

      if (press_evt) begin
        if (!valid_q || key.i_Key_Ready) begin
          code_q  <= cand[CODE_W-1:0];
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && key.i_Key_Ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign key.o_Key_Code  = code_q;
  assign key.o_Key_Valid = valid_q;
  assign key.o_Key_Held  = (accepted != KEY_NONE);
  assign key.o_Overrun   = overrun_q;
  assign key.dbg_state   = state;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
// Directed bench for keypad_matrix_scanner with default parameters
// (4x4 matrix, 16-cycle settle, 4-scan debounce, 64-cycle scan).
// Cycle 0 is the first cycle after the last reset edge; scan k has its EVAL
// at cycle 64k and any resulting event is visible at cycle 64k+1.
module tb_keypad_matrix_scanner;
  import keypad_matrix_scanner_pkg::*;

  localparam int ROW_NUM = 4;
  localparam int COL_NUM = 4;
  localparam int W       = code_width(ROW_NUM * COL_NUM);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ROW_NUM-1:0]         rows;
  logic [COL_NUM-1:0]         cols;
  logic [ROW_NUM*COL_NUM-1:0] pressed = '0;

  keypad_matrix_scanner_if #(.CODE_W(W)) key ();

  keypad_matrix_scanner #(
    .ROW_NUM        (ROW_NUM),
    .COL_NUM        (COL_NUM),
    .SETTLE_CYCLES  (16),
    .DEBOUNCE_SCANS (4)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .i_Rows  (rows),
    .o_Cols  (cols),
    .key     (key)
  );

  // Physical key matrix: a pressed key pulls its row low while its column
  // is driven low.
  always_comb begin
    rows = '1;
    for (int r = 0; r < ROW_NUM; r++) begin
      for (int c = 0; c < COL_NUM; c++) begin
        if (pressed[r*COL_NUM+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  int cyc  = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp   = 0;
  int n_err   = 0;
  int ovr_cnt = 0;
  int ovr_cyc = -1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc - base);
    end
  endtask

  task automatic expect_event(input logic [W-1:0] code, input int at_cyc);
    exp_q.push_back(code);
    exp_cyc_q.push_back(at_cyc);
  endtask

  task automatic expect_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // Monitor: samples just after the falling edge, pops on every transfer.
  always begin
    @(negedge clk);
    #1;
    if (!rst && key.o_Key_Valid && key.i_Key_Ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got code %0d at cycle %0d, required no event",
                 key.o_Key_Code, cyc - base);
      end else begin
        logic [W-1:0] ec;
        int           et;
        ec = exp_q.pop_front();
        et = exp_cyc_q.pop_front();
        check("event_code", 32'(key.o_Key_Code), 32'(ec));
        if (et >= 0) check("event_cycle", cyc - base, et);
      end
    end
    if (!rst && key.o_Overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc - base;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic wait_until(input int t);
    while ((cyc - base) < t) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    key.i_Key_Ready = 1'b1;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cols",    32'(cols), 32'b1110);
    check("rst_code",    32'(key.o_Key_Code), 0);
    check("rst_valid",   32'(key.o_Key_Valid), 0);
    check("rst_held",    32'(key.o_Key_Held), 0);
    check("rst_overrun", 32'(key.o_Overrun), 0);
    rst  = 1'b0;
    base = cyc;

    // Idle scanning: column walk, nothing valid or held
    for (int t = 0; t < 128; t++) begin
      logic [3:0] exp_cols;
      wait_until(t);
      exp_cols = ~(4'b0001 << ((t / 16) % 4));
      check("idle_cols", 32'(cols), 32'(exp_cols));
      if (t % 16 == 0) begin
        check("idle_valid", 32'(key.o_Key_Valid), 0);
        check("idle_held",  32'(key.o_Key_Held), 0);
      end
    end
    expect_drained("idle_drain");

    // Key 9 (row 2, col 1) held 6 scans, then released
    do_reset(2);
    pressed[9] = 1'b1;
    expect_event(W'(9), 257);
    wait_until(256);
    check("k9_held_pre", 32'(key.o_Key_Held), 0);
    wait_until(257);
    check("k9_held", 32'(key.o_Key_Held), 1);
    check("k9_valid", 32'(key.o_Key_Valid), 1);
    wait_until(258);
    check("k9_valid_drop", 32'(key.o_Key_Valid), 0);
    wait_until(384);
    pressed[9] = 1'b0;
    wait_until(640);
    check("k9_held_release_pre", 32'(key.o_Key_Held), 1);
    wait_until(641);
    check("k9_held_release", 32'(key.o_Key_Held), 0);
    wait_until(700);
    expect_drained("k9_drain");

    // Key 9 bouncing every 50 cycles for 300 cycles, then held
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      wait_until(50 * i);
      pressed[9] = (i % 2 == 0);
    end
    wait_until(300);
    pressed[9] = 1'b1;
    expect_event(W'(9), 577);
    wait_until(576);
    check("bounce_held_pre", 32'(key.o_Key_Held), 0);
    wait_until(577);
    check("bounce_held", 32'(key.o_Key_Held), 1);
    wait_until(600);
    pressed = '0;
    expect_drained("bounce_drain");

    // Ghosting: keys 0 and 5 together, then key 5 released
    do_reset(2);
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    wait_until(320);
    check("ghost_held",  32'(key.o_Key_Held), 0);
    check("ghost_valid", 32'(key.o_Key_Valid), 0);
    pressed[5] = 1'b0;
    expect_event(W'(0), 577);
    wait_until(577);
    check("ghost_k0_held", 32'(key.o_Key_Held), 1);
    wait_until(600);
    pressed = '0;
    expect_drained("ghost_drain");

    // Backpressure: key 3 waits unconsumed, key 7's event is dropped
    check("no_overrun_yet", ovr_cnt, 0);
    key.i_Key_Ready = 1'b0;
    do_reset(2);
    pressed[3] = 1'b1;
    wait_until(257);
    check("bp_valid", 32'(key.o_Key_Valid), 1);
    check("bp_code",  32'(key.o_Key_Code), 3);
    wait_until(320);
    pressed[3] = 1'b0;
    wait_until(640);
    pressed[7] = 1'b1;
    wait_until(900);
    check("bp_overrun_cnt", ovr_cnt, 1);
    check("bp_overrun_cyc", ovr_cyc, 897);
    check("bp_code_hold",   32'(key.o_Key_Code), 3);
    check("bp_valid_hold",  32'(key.o_Key_Valid), 1);
    check("bp_held7",       32'(key.o_Key_Held), 1);
    wait_until(960);
    expect_event(W'(3), -1);
    key.i_Key_Ready = 1'b1;
    wait_until(961);
    check("bp_valid_drop", 32'(key.o_Key_Valid), 0);
    wait_until(1100);
    pressed = '0;
    check("bp_overrun_final", ovr_cnt, 1);
    expect_drained("bp_drain");

    // Reset mid-debounce: key 6 stable for 2 scans, then a 1-cycle reset
    do_reset(2);
    pressed[6] = 1'b1;
    wait_until(150);
    do_reset(1);
    check("rr_cols0", 32'(cols), 32'b1110);
    expect_event(W'(6), 257);
    wait_until(16);
    check("rr_cols1", 32'(cols), 32'b1101);
    wait_until(256);
    check("rr_held_pre", 32'(key.o_Key_Held), 0);
    wait_until(257);
    check("rr_held", 32'(key.o_Key_Held), 1);
    wait_until(300);
    pressed = '0;
    expect_drained("rr_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
